// File: rtl/griffin_batch_loader.sv
// griffin_batch_loader
//   Serial-to-parallel batch loader/unloader around a multi-lane Griffin
//   permutation core. Words arrive on a valid/ready stream and are packed
//   lane-major (w = lane*STATE_SIZE + elem) into the core input buffer. A
//   one-cycle core_start pulse launches the core. The result is captured on
//   core_done and then streamed back out with out_last on the final word.
//
//   Optional macro GRIFFIN_PARTIAL_BATCH_EN: adds in_last so that a batch
//   may end early. Unwritten input words are zeroed, and only the loaded
//   count is drained.
module griffin_batch_loader #(
  parameter int unsigned N_BITS     = 254,
  parameter int unsigned STATE_SIZE = 3,
  parameter int unsigned NUM_LANES  = 13,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [N_BITS-1:0]                      in_data,
`ifdef GRIFFIN_PARTIAL_BATCH_EN
  input  logic                                   in_last,
`endif
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [N_BITS-1:0]                      out_data,
  output logic                                   out_last,
  output logic                                   core_start,
  output logic [NUM_LANES*STATE_SIZE*N_BITS-1:0] core_state_in,
  input  logic                                   core_done,
  input  logic [NUM_LANES*STATE_SIZE*N_BITS-1:0] core_state_out,
  output logic                                   busy,
  output logic [CNT_BITS-1:0]                    batch_cnt
);

  localparam int unsigned TOTAL = NUM_LANES * STATE_SIZE;
  localparam int unsigned PTR_W = $clog2(TOTAL + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      last_idx_q, last_idx_d;
  logic [CNT_BITS-1:0]   batch_cnt_q, batch_cnt_d;
  logic [N_BITS-1:0]     buf_in_q  [TOTAL];
  logic [N_BITS-1:0]     buf_in_d  [TOTAL];
  logic [N_BITS-1:0]     buf_out_q [TOTAL];
  logic [N_BITS-1:0]     buf_out_d [TOTAL];

  logic in_fire;
  logic out_fire;
  logic capture;
  logic word_last;

  // Early-end marker for the word currently offered on the input stream.
  always_comb begin
`ifdef GRIFFIN_PARTIAL_BATCH_EN
    word_last = in_last;
`else
    word_last = 1'b0;
`endif
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // FSM next-state, pointer/counter updates and stream outputs.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_idx_d  = last_idx_q;
    batch_cnt_d = batch_cnt_q;
    capture     = 1'b0;
    in_ready    = (state_q == S_LOAD);
    core_start  = (state_q == S_START);
    out_valid   = (state_q == S_DRAIN);
    out_data    = '0;
    out_last    = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          if ((wr_ptr_q == LAST_IDX) || word_last) begin
            // The index of the final loaded word bounds the following drain.
            last_idx_d = wr_ptr_q;
            wr_ptr_d   = '0;
            state_d    = S_START;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          capture = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_data = buf_out_q[rd_ptr_q];
        out_last = (rd_ptr_q == last_idx_q);
        if (out_fire) begin
          if (out_last) begin
            rd_ptr_d    = '0;
            batch_cnt_d = batch_cnt_q + 1'b1;
            state_d     = S_LOAD;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Buffer updates: input word write (plus tail zeroing on early end) and result capture.
  always_comb begin
    for (int unsigned i = 0; i < TOTAL; i++) begin
      buf_in_d[i]  = buf_in_q[i];
      buf_out_d[i] = capture ? core_state_out[i*N_BITS +: N_BITS] : buf_out_q[i];
      if (in_fire) begin
        if (PTR_W'(i) == wr_ptr_q) begin
          buf_in_d[i] = in_data;
        end else if (word_last && (PTR_W'(i) > wr_ptr_q)) begin
          buf_in_d[i] = '0;
        end
      end
    end
  end

  // Flatten the input buffer onto the core input bus.
  always_comb begin
    core_state_in = '0;
    for (int unsigned i = 0; i < TOTAL; i++) begin
      core_state_in[i*N_BITS +: N_BITS] = buf_in_q[i];
    end
  end

  assign busy      = !((state_q == S_LOAD) && (wr_ptr_q == '0));
  assign batch_cnt = batch_cnt_q;

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_idx_q  <= LAST_IDX;
      batch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_idx_q  <= last_idx_d;
      batch_cnt_q <= batch_cnt_d;
    end
  end

  // Data buffers are not reset; their contents only matter once a batch is loaded.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < TOTAL; i++) begin
      buf_in_q[i]  <= buf_in_d[i];
      buf_out_q[i] <= buf_out_d[i];
    end
  end

endmodule

// File: tb/tb_griffin_batch_loader.sv
module tb_griffin_batch_loader;

  localparam int NB  = 254;
  localparam int SS  = 3;
  localparam int NL  = 13;
  localparam int CB  = 16;
  localparam int TOT = NL * SS;
  localparam int CORE_LAT = 10;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [NB-1:0]     in_data;
`ifdef GRIFFIN_PARTIAL_BATCH_EN
  logic              in_last;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [NB-1:0]     out_data;
  logic              out_last;
  logic              core_start;
  logic [TOT*NB-1:0] core_state_in;
  logic              core_done;
  logic [TOT*NB-1:0] core_state_out;
  logic              busy;
  logic [CB-1:0]     batch_cnt;

  logic              model_done;
  logic              spur_done;
  logic [TOT*NB-1:0] snap;

  logic [NB-1:0]     exp_q[$];
  int                total;
  int                bad;
  int                starts;

  assign core_done = model_done | spur_done;

  griffin_batch_loader #(
    .N_BITS    (NB),
    .STATE_SIZE(SS),
    .NUM_LANES (NL),
    .CNT_BITS  (CB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
`ifdef GRIFFIN_PARTIAL_BATCH_EN
    .in_last       (in_last),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .core_start    (core_start),
    .core_state_in (core_state_in),
    .core_done     (core_done),
    .core_state_out(core_state_out),
    .busy          (busy),
    .batch_cnt     (batch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: snapshot on start, return every word +5 after CORE_LAT cycles.
  initial begin
    model_done     = 1'b0;
    core_state_out = '0;
    snap           = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        snap = core_state_in;
        repeat (CORE_LAT) @(negedge clk);
        for (int w = 0; w < TOT; w++) begin
          core_state_out[w*NB +: NB] = snap[w*NB +: NB] + NB'(5);
        end
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  // Count start pulses (one per high cycle).
  initial begin
    starts = 0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) starts++;
    end
  end

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed n words base..base+n-1; optionally push expected results; optional spurious done.
  task automatic load(input int n, input logic [NB-1:0] base, input bit push,
                      input int spur_at, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = base + NB'(i);
`ifdef GRIFFIN_PARTIAL_BATCH_EN
      in_last   = use_last && (i == n - 1);
`endif
      spur_done = (i == spur_at);
      check("load_in_ready", NB'(in_ready), NB'(1));
      if (push) exp_q.push_back(base + NB'(i) + NB'(5));
      step();
    end
    in_valid  = 1'b0;
    spur_done = 1'b0;
`ifdef GRIFFIN_PARTIAL_BATCH_EN
    in_last   = 1'b0;
`endif
    if (use_last) begin end
    check("start_after_load", NB'(core_start), NB'(1));
  endtask

  // Drain n words; mode 0 = always ready, mode 1 = ready pattern 1,0,0,1.
  task automatic drain(input int n, input int mode);
    int            got;
    int            cyc;
    int            ph;
    bit            stalled;
    bit            ready_seen;
    logic [NB-1:0] held;
    logic          held_last;
    logic [NB-1:0] exp;
    got        = 0;
    cyc        = 0;
    ph         = 0;
    stalled    = 1'b0;
    ready_seen = 1'b0;
    held       = '0;
    held_last  = 1'b0;
    while (got < n && cyc < 1000) begin
      if (in_ready) ready_seen = 1'b1;
      if (out_valid) begin
        out_ready = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
        ph++;
        if (stalled) begin
          check("hold_data", out_data, held);
          check("hold_last", NB'(out_last), NB'(held_last));
        end
        if (out_ready) begin
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          else exp = '1;
          check("out_data", out_data, exp);
          check("out_last", NB'(out_last), NB'(got == n - 1));
          got++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held      = out_data;
          held_last = out_last;
        end
      end else begin
        out_ready = 1'b0;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", NB'(got), NB'(n));
    check("in_ready_low_while_busy", NB'(ready_seen), NB'(0));
    check("in_ready_after_last", NB'(in_ready), NB'(1));
    check("out_valid_after_last", NB'(out_valid), NB'(0));
  endtask

  initial begin
    int            s0;
    bit            saw;
    logic [NB-1:0] base;
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    spur_done = 1'b0;
`ifdef GRIFFIN_PARTIAL_BATCH_EN
    in_last   = 1'b0;
`endif
    repeat (3) step();

    // Reset state
    check("rst_in_ready", NB'(in_ready), NB'(1));
    check("rst_out_valid", NB'(out_valid), NB'(0));
    check("rst_out_data", out_data, NB'(0));
    check("rst_out_last", NB'(out_last), NB'(0));
    check("rst_core_start", NB'(core_start), NB'(0));
    check("rst_batch_cnt", NB'(batch_cnt), NB'(0));
    check("rst_busy", NB'(busy), NB'(0));
    reset = 1'b1;
    step();

    // Full batch, words 1..39, results 6..44
    base = NB'(1);
    load(TOT, base, 1'b1, -1, 1'b0);
    check("start_busy", NB'(busy), NB'(1));
    check("start_in_ready", NB'(in_ready), NB'(0));
    step();
    check("start_one_cycle", NB'(core_start), NB'(0));
    check("wait_in_ready", NB'(in_ready), NB'(0));
    check("wait_out_valid", NB'(out_valid), NB'(0));
    drain(TOT, 0);
    check("cnt_after_1", NB'(batch_cnt), NB'(1));
    check("starts_after_1", NB'(starts), NB'(1));
    check("busy_idle", NB'(busy), NB'(0));

    // Backpressure drain
    base = NB'(100);
    load(TOT, base, 1'b1, -1, 1'b0);
    drain(TOT, 1);
    check("cnt_after_bp", NB'(batch_cnt), NB'(2));

    // Spurious done during LOAD after 5 words
    base = NB'(300);
    load(TOT, base, 1'b1, 5, 1'b0);
    drain(TOT, 0);
    check("cnt_after_spur", NB'(batch_cnt), NB'(3));
    check("starts_after_spur", NB'(starts), NB'(3));

    // Reset while waiting for the core
    base = NB'(500);
    load(TOT, base, 1'b0, -1, 1'b0);
    repeat (4) step();
    check("wait_busy", NB'(busy), NB'(1));
    reset = 1'b0;
    #1;
    check("rstw_out_valid", NB'(out_valid), NB'(0));
    check("rstw_batch_cnt", NB'(batch_cnt), NB'(0));
    check("rstw_in_ready", NB'(in_ready), NB'(1));
    step();
    reset = 1'b1;
    s0  = starts;
    saw = 1'b0;
    repeat (2 * CORE_LAT) begin
      step();
      if (out_valid) saw = 1'b1;
    end
    check("late_done_ignored", NB'(saw), NB'(0));
    check("no_start_after_rst", NB'(starts), NB'(s0));
    check("idle_after_rst", NB'(busy), NB'(0));

    // Back-to-back batches, no idle gap
    base = NB'(1000);
    load(TOT, base, 1'b1, -1, 1'b0);
    drain(TOT, 0);
    base = NB'(2000);
    load(TOT, base, 1'b1, -1, 1'b0);
    drain(TOT, 0);
    check("cnt_after_b2b", NB'(batch_cnt), NB'(2));

`ifdef GRIFFIN_PARTIAL_BATCH_EN
    // Partial batch of 7 words
    base = NB'(4000);
    load(7, base, 1'b1, -1, 1'b1);
    check("partial_tail_zero", NB'(|core_state_in[TOT*NB-1:7*NB]), NB'(0));
    check("partial_word6", core_state_in[6*NB +: NB], base + NB'(6));
    drain(7, 0);
    check("cnt_after_partial", NB'(batch_cnt), NB'(3));
`endif

    check("scoreboard_empty", NB'(exp_q.size()), NB'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
